// File: rtl/mat_pkg.sv
// Shared types and defaults for the weight-stationary systolic matrix unit.
package mat_pkg;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAccW  = 32;

  // Accept edge to out_valid edge: input reg + skew + array + deskew + output reg.
  function automatic int unsigned calc_lat(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mat_pe.sv
// Registered MAC cell: forwards the input right and the partial sum down.
module mat_pe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] a_in,
  output logic signed [DATA_W-1:0] a_out,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [ACC_W-1:0]  psum_in,
  output logic signed [ACC_W-1:0]  psum_out,
  input  logic                     v_in,
  output logic                     v_out
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = a_in * weight;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_out    <= '0;
      psum_out <= '0;
      v_out    <= 1'b0;
    end else begin
      a_out    <= a_in;
      psum_out <= psum_in + ACC_W'(prod);
      v_out    <= v_in;
    end
  end

endmodule

// File: rtl/systolic_mat_unit.sv
// Weight-stationary systolic matrix unit with built-in skew/deskew and a
// double-buffered weight bank swapped in via a drain-then-swap handshake.
module systolic_mat_unit
  import mat_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*DATA_W-1:0]    in_data,
  output logic                       out_valid,
  output logic [WIDTH*ACC_W-1:0]     out_data,
  input  logic                       ld_valid,
  input  logic [$clog2(WIDTH)-1:0]   ld_row,
  input  logic [WIDTH*DATA_W-1:0]    ld_data,
  input  logic                       swap_req,
  output logic                       swap_done,
  output logic                       busy
);

  localparam int unsigned Lat  = calc_lat(WIDTH);
  localparam int unsigned CntW = $clog2(Lat + 1) + 1;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  state_e            state_q, state_d;
  logic              accept, drained, swap_fire, swap_done_q, out_valid_q, in_v_q;
  logic [CntW-1:0]   inflight_q;
  elem_t             in_q     [WIDTH];
  elem_t             shadow_q [WIDTH][WIDTH];
  elem_t             active_q [WIDTH][WIDTH];
  elem_t             a_h      [WIDTH][WIDTH+1];
  acc_t              ps_v     [WIDTH+1][WIDTH];
  logic              v_o      [WIDTH][WIDTH];
  acc_t              dsk_d    [WIDTH];
  logic [WIDTH-1:0]  dsk_v;
  acc_t              out_q    [WIDTH];

  assign accept  = in_valid && in_ready;
  assign drained = (inflight_q == '0) && !out_valid_q;

  // FSM: state register, next state, outputs.
  always_ff @(posedge clock) begin
    if (reset) state_q <= StRun;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (swap_req) state_d = StDrain;
      StDrain: if (drained)  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    swap_fire = 1'b0;
    unique case (state_q)
      StRun:   in_ready  = 1'b1;
      StDrain: swap_fire = drained;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q  <= '0;
      swap_done_q <= 1'b0;
    end else begin
      swap_done_q <= swap_fire;
      case ({accept, out_valid_q})
        2'b10:   inflight_q <= inflight_q + CntW'(1);
        2'b01:   inflight_q <= inflight_q - CntW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // On a swap edge with a concurrent load, active gets the pre-write shadow.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        for (int j = 0; j < WIDTH; j++) begin
          shadow_q[i][j] <= '0;
          active_q[i][j] <= '0;
        end
      end
    end else begin
      if (ld_valid && (32'(ld_row) < WIDTH)) begin
        for (int j = 0; j < WIDTH; j++) shadow_q[ld_row][j] <= ld_data[j*DATA_W +: DATA_W];
      end
      if (swap_fire) active_q <= shadow_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_v_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) in_q[i] <= '0;
    end else begin
      in_v_q <= accept;
      for (int i = 0; i < WIDTH; i++) in_q[i] <= accept ? in_data[i*DATA_W +: DATA_W] : '0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = in_q[0];
    end else begin : g_delay
      elem_t sr_q [i];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int k = 0; k < i; k++) sr_q[k] <= '0;
        end else begin
          sr_q[0] <= in_q[i];
          for (int k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign a_h[i][0] = sr_q[i-1];
    end
  end

  for (genvar j = 0; j < WIDTH; j++) begin : g_top
    assign ps_v[0][j] = '0;
  end

  // Valid runs along row 0 with the data, then down each column with the psum.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
      logic v_in;
      if (i == 0 && j == 0) begin : g_v0
        assign v_in = in_v_q;
      end else if (i == 0) begin : g_vr
        assign v_in = v_o[0][j-1];
      end else begin : g_vd
        assign v_in = v_o[i-1][j];
      end
      mat_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clock   (clock),
        .reset   (reset),
        .a_in    (a_h[i][j]),
        .a_out   (a_h[i][j+1]),
        .weight  (active_q[i][j]),
        .psum_in (ps_v[i][j]),
        .psum_out(ps_v[i+1][j]),
        .v_in    (v_in),
        .v_out   (v_o[i][j])
      );
    end
  end

  for (genvar j = 0; j < WIDTH; j++) begin : g_dsk
    localparam int unsigned Dly = WIDTH - 1 - j;
    if (Dly == 0) begin : g_direct
      assign dsk_d[j] = ps_v[WIDTH][j];
      assign dsk_v[j] = v_o[WIDTH-1][j];
    end else begin : g_delay
      acc_t sd_q [Dly];
      logic sv_q [Dly];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int k = 0; k < Dly; k++) begin
            sd_q[k] <= '0;
            sv_q[k] <= 1'b0;
          end
        end else begin
          sd_q[0] <= ps_v[WIDTH][j];
          sv_q[0] <= v_o[WIDTH-1][j];
          for (int k = 1; k < Dly; k++) begin
            sd_q[k] <= sd_q[k-1];
            sv_q[k] <= sv_q[k-1];
          end
        end
      end
      assign dsk_d[j] = sd_q[Dly-1];
      assign dsk_v[j] = sv_q[Dly-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      for (int j = 0; j < WIDTH; j++) out_q[j] <= '0;
    end else begin
      out_valid_q <= &dsk_v;
      for (int j = 0; j < WIDTH; j++) out_q[j] <= (&dsk_v) ? dsk_d[j] : '0;
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < WIDTH; j++) out_data[j*ACC_W +: ACC_W] = out_valid_q ? out_q[j] : '0;
  end

  assign out_valid = out_valid_q;
  assign swap_done = swap_done_q;
  assign busy      = (state_q == StDrain) || (inflight_q != '0);

endmodule
